// File: rtl/vme_irq_handler_v2_if.sv
// IACK handshake between the interrupt handler and the VME master cycle engine.
// master: the cycle engine (runs the IACK cycle, returns dtack/berr/status_id).
// slave : the interrupt handler (requests the cycle and supplies the level).
interface vme_irq_handler_v2_if #(
  parameter int ID_W  = 8,
  parameter int LVL_W = 3
);
  logic             irq;
  logic [LVL_W-1:0] vec_addr;
  logic             iack;
  logic             dtack;
  logic             berr;
  logic [ID_W-1:0]  status_id;

  modport master (
    output iack, dtack, berr, status_id,
    input  irq, vec_addr
  );

  modport slave (
    input  iack, dtack, berr, status_id,
    output irq, vec_addr
  );
endinterface

// File: rtl/vme_irq_handler_v2.sv
// VME interrupt handler: synchronises the active-low IRQ lines, picks the
// highest enabled level, requests an IACK cycle, captures the status/ID or
// reports berr/timeout, then holds off so a ROAK requester can release.
module vme_irq_handler_v2 #(
  parameter  int NUM_LEVELS     = 7,
  parameter  int SYNC_STAGES    = 2,
  parameter  int ID_W           = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  parameter  int HOLDOFF_CYCLES = 4,
  localparam int LVL_W          = $clog2(NUM_LEVELS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_LEVELS-1:0] irq_n,
  input  logic [NUM_LEVELS-1:0] level_mask,
  vme_irq_handler_v2_if.slave   bus,
  output logic                  id_valid,
  output logic [ID_W-1:0]       id_data,
  output logic [LVL_W-1:0]      id_level,
  output logic                  err,
  output logic                  err_code,
  output logic                  busy
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int HO_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  // Timeout fires on the cycle the counter holds TIMEOUT_CYCLES-1, i.e. the
  // TIMEOUT_CYCLES-th ACK cycle after irq rose.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t                              r_state;
  logic [SYNC_STAGES-1:0][NUM_LEVELS-1:0] r_sync;
  logic [TO_W-1:0]                     r_to_cnt;
  logic [HO_W-1:0]                     r_ho_cnt;
  logic                                r_irq;
  logic [LVL_W-1:0]                    r_vec_addr;
  logic                                r_id_valid;
  logic [ID_W-1:0]                     r_id_data;
  logic [LVL_W-1:0]                    r_id_level;
  logic                                r_err;
  logic                                r_err_code;

  logic [NUM_LEVELS-1:0]               w_active;
  logic                                w_any;
  logic [LVL_W-1:0]                    w_top;

  // Multi-flop synchroniser for the asynchronous backplane IRQ lines (idle high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_n};
    end
  end

  assign w_active = ~r_sync[SYNC_STAGES-1] & level_mask;
  assign w_any    = |w_active;

  // Fixed-priority encoder: highest set bit wins, result is 1-based level.
  always_comb begin
    w_top = '0;
    for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
      if (w_active[i]) begin
        w_top = LVL_W'(i + 1);
      end
    end
  end

  // Control FSM with registered outputs: arbitrate, run IACK, hold off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_to_cnt   <= '0;
      r_ho_cnt   <= '0;
      r_irq      <= 1'b0;
      r_vec_addr <= '0;
      r_id_valid <= 1'b0;
      r_id_data  <= '0;
      r_id_level <= '0;
      r_err      <= 1'b0;
      r_err_code <= 1'b0;
    end else begin
      r_id_valid <= 1'b0;
      r_err      <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_vec_addr <= w_top;
            r_irq      <= 1'b1;
            r_to_cnt   <= '0;
            r_state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          // Bus responses take precedence over an expiring timeout, and berr
          // takes precedence over dtack.
          if (bus.iack && bus.berr) begin
            r_err      <= 1'b1;
            r_err_code <= 1'b0;
            r_irq      <= 1'b0;
            r_ho_cnt   <= '0;
            r_state    <= ST_HOLDOFF;
          end else if (bus.iack && bus.dtack) begin
            r_id_valid <= 1'b1;
            r_id_data  <= bus.status_id;
            r_id_level <= r_vec_addr;
            r_irq      <= 1'b0;
            r_ho_cnt   <= '0;
            r_state    <= ST_HOLDOFF;
          end else if ((TIMEOUT_CYCLES != 0) && (r_to_cnt >= TO_LAST)) begin
            r_err      <= 1'b1;
            r_err_code <= 1'b1;
            r_irq      <= 1'b0;
            r_ho_cnt   <= '0;
            r_state    <= ST_HOLDOFF;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (r_ho_cnt >= HO_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_ho_cnt <= r_ho_cnt + 1'b1;
          end
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.irq      = r_irq;
  assign bus.vec_addr = r_vec_addr;
  assign id_valid     = r_id_valid;
  assign id_data      = r_id_data;
  assign id_level     = r_id_level;
  assign err          = r_err;
  assign err_code     = r_err_code;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vme_irq_handler_v2.sv
// Self-checking bench for vme_irq_handler_v2 with a completion scoreboard.
module tb_vme_irq_handler_v2;
  localparam int NL  = 7;
  localparam int IDW = 8;
  localparam int LW  = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NL-1:0] irq_n;
  logic [NL-1:0] level_mask;
  logic          id_valid;
  logic [IDW-1:0] id_data;
  logic [LW-1:0] id_level;
  logic          err;
  logic          err_code;
  logic          busy;

  always #5 clk = ~clk;

  vme_irq_handler_v2_if #(.ID_W(IDW), .LVL_W(LW)) bus ();

  vme_irq_handler_v2 #(
    .NUM_LEVELS    (NL),
    .SYNC_STAGES   (2),
    .ID_W          (IDW),
    .TIMEOUT_CYCLES(16),
    .HOLDOFF_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .irq_n     (irq_n),
    .level_mask(level_mask),
    .bus       (bus),
    .id_valid  (id_valid),
    .id_data   (id_data),
    .id_level  (id_level),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic           is_err;
    logic [IDW-1:0] data;
    logic [LW-1:0]  level;
    logic           code;
  } exp_t;

  exp_t sb_q[$];

  // Completion monitor: every id_valid/err pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n === 1'b1 && (id_valid === 1'b1 || err === 1'b1)) begin
      check_eq("pulse_exclusive", {31'd0, id_valid & err}, 32'd0);
      if (sb_q.size() == 0) begin
        check_eq("unexpected_pulse", {31'd0, id_valid | err}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("evt_kind", {31'd0, err}, {31'd0, e.is_err});
        if (e.is_err) begin
          check_eq("err_code", {31'd0, err_code}, {31'd0, e.code});
        end else begin
          check_eq("id_data", {24'd0, id_data}, {24'd0, e.data});
          check_eq("id_level", {29'd0, id_level}, {29'd0, e.level});
        end
      end
    end
  end

  task automatic wait_irq(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.irq !== 1'b1 && n < max);
    check_eq("irq_seen", {31'd0, bus.irq}, 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_eq("busy_low", {31'd0, busy}, 32'd0);
  endtask

  // Emulate the master engine returning dtack with a status/ID.
  task automatic complete(input logic [IDW-1:0] sid, input logic [LW-1:0] lvl);
    exp_t e;
    e.is_err = 1'b0; e.data = sid; e.level = lvl; e.code = 1'b0;
    sb_q.push_back(e);
    bus.iack = 1'b1; bus.dtack = 1'b1; bus.status_id = sid;
    @(negedge clk);
    bus.iack = 1'b0; bus.dtack = 1'b0;
  endtask

  task automatic push_err(input logic [LW-1:0] lvl, input logic code);
    exp_t e;
    e.is_err = 1'b1; e.data = '0; e.level = lvl; e.code = code;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    reset_n = 1'b0;
    irq_n = '1;
    level_mask = '0;
    bus.iack = 1'b0; bus.dtack = 1'b0; bus.berr = 1'b0; bus.status_id = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_irq", {31'd0, bus.irq}, 32'd0);
    check_eq("rst_vec", {29'd0, bus.vec_addr}, 32'd0);
    check_eq("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rst_id_data", {24'd0, id_data}, 32'd0);
    check_eq("rst_id_level", {29'd0, id_level}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_err_code", {31'd0, err_code}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: single level 3 request and completion
    level_mask = 7'h7F;
    irq_n = 7'b1111011;
    wait_irq(20, n);
    check_eq("t1_latency", n, 3);
    check_eq("t1_vec", {29'd0, bus.vec_addr}, 32'd3);
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    complete(8'hA5, 3'd3);
    check_eq("t1_irq_low", {31'd0, bus.irq}, 32'd0);
    check_eq("t1_id_data", {24'd0, id_data}, 32'hA5);
    check_eq("t1_id_level", {29'd0, id_level}, 32'd3);
    irq_n = '1;
    wait_idle(n);
    check_eq("t1_holdoff", n, 5);

    // 2: levels 2 and 6 together, 6 released mid-ACK
    irq_n = 7'b1011101;
    wait_irq(20, n);
    check_eq("t2_vec_first", {29'd0, bus.vec_addr}, 32'd6);
    irq_n = 7'b1111101;
    repeat (3) @(negedge clk);
    check_eq("t2_irq_held", {31'd0, bus.irq}, 32'd1);
    check_eq("t2_vec_held", {29'd0, bus.vec_addr}, 32'd6);
    complete(8'h3C, 3'd6);
    wait_irq(30, n);
    check_eq("t2_rearb_delay", n, 6);
    check_eq("t2_vec_second", {29'd0, bus.vec_addr}, 32'd2);
    complete(8'h5A, 3'd2);
    irq_n = '1;
    wait_idle(n);

    // 3: masked level 7 is ignored until enabled
    level_mask = 7'h3F;
    irq_n = 7'b0111111;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.irq === 1'b1) seen = 1;
    end
    check_eq("t3_masked", seen, 0);
    level_mask = 7'h7F;
    wait_irq(10, n);
    check_eq("t3_unmask_delay", n, 1);
    check_eq("t3_vec", {29'd0, bus.vec_addr}, 32'd7);
    complete(8'hC3, 3'd7);
    irq_n = '1;
    wait_idle(n);

    // 4: timeout after 16 ACK cycles; dtack without iack is ignored
    irq_n = 7'b1110111;
    wait_irq(20, n);
    check_eq("t4_vec", {29'd0, bus.vec_addr}, 32'd4);
    push_err(3'd4, 1'b1);
    bus.dtack = 1'b1; bus.status_id = 8'hFF;
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4_timeout_at", n, 16);
    check_eq("t4_irq_low", {31'd0, bus.irq}, 32'd0);
    check_eq("t4_id_data_kept", {24'd0, id_data}, 32'hC3);
    bus.dtack = 1'b0;
    irq_n = '1;
    wait_idle(n);

    // 5: berr and dtack together -> berr wins, id_data unchanged
    irq_n = 7'b1111110;
    wait_irq(20, n);
    check_eq("t5_vec", {29'd0, bus.vec_addr}, 32'd1);
    push_err(3'd1, 1'b0);
    bus.iack = 1'b1; bus.dtack = 1'b1; bus.berr = 1'b1; bus.status_id = 8'h99;
    @(negedge clk);
    bus.iack = 1'b0; bus.dtack = 1'b0; bus.berr = 1'b0;
    check_eq("t5_irq_low", {31'd0, bus.irq}, 32'd0);
    check_eq("t5_id_data_kept", {24'd0, id_data}, 32'hC3);
    check_eq("t5_id_level_kept", {29'd0, id_level}, 32'd7);
    irq_n = '1;
    wait_idle(n);

    // 6: asynchronous reset in the middle of ACK
    irq_n = 7'b1101111;
    wait_irq(20, n);
    check_eq("t6_vec", {29'd0, bus.vec_addr}, 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_irq", {31'd0, bus.irq}, 32'd0);
    check_eq("t6_rst_vec", {29'd0, bus.vec_addr}, 32'd0);
    check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_rst_id_data", {24'd0, id_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_irq(20, n);
    check_eq("t6_rereq_latency", n, 3);
    check_eq("t6_vec_again", {29'd0, bus.vec_addr}, 32'd5);
    complete(8'h77, 3'd5);
    irq_n = '1;
    wait_idle(n);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
